// File: rtl/ysyx_25020047_mem_pkg.sv
// Shared definitions for the LSU memory slave: FSM encoding, byte-mask width,
// default base address and a byte-mask expander that the LSU reuses.
package ysyx_25020047_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam int          MASK_W       = 4;
  localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

  function automatic logic [31:0] wmask_expand(input logic [MASK_W-1:0] wmask);
    logic [31:0] bits_s;
    bits_s = 32'h0000_0000;
    for (int i = 0; i < MASK_W; i++) begin
      bits_s[8*i +: 8] = {8{wmask[i]}};
    end
    return bits_s;
  endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_sram_chk.sv
// Simulation checker for the memory slave request interface.
module ysyx_25020047_lsu_sram_chk (
  input logic clk,
  input logic rst_n,
  input logic req_valid
);

  // req_valid must always be a known value outside reset
  a_req_valid_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req_valid))
    else $error("req_valid is X/Z");

endmodule

// File: rtl/ysyx_25020047_sram_array.sv
// Single-port DEPTH_WORDS x 32 storage with byte write enables; read data is
// registered on the enable edge and returns the pre-write contents.
module ysyx_25020047_sram_array
  import ysyx_25020047_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [MASK_W-1:0] be,
  input  logic [AW-1:0]     idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Storage update and registered read, no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (be[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem_r[idx];
    end
  end

endmodule

// File: rtl/ysyx_25020047_lsu_sram.sv
// Word-wide SRAM slave for the LSU: valid/ready request, fixed-latency
// response, range check with error response and byte-masked writes.
module ysyx_25020047_lsu_sram
  import ysyx_25020047_mem_pkg::*;
#(
  parameter logic [31:0] BASE        = DEFAULT_BASE,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LAT         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  mem_state_e        state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              req_ready_r, resp_valid_r;
  logic              err_r, rd_gate_r;
  logic              wen_r;
  logic [31:0]       addr_r, wdata_r;
  logic [MASK_W-1:0] wmask_r;

  logic              accept_s, latch_s, commit_s;
  logic              acc_wen_s, oor_s;
  logic [31:0]       acc_addr_s, acc_wdata_s, off_s;
  logic [MASK_W-1:0] acc_wmask_s, arr_be_s;
  logic [31:0]       arr_rdata_s;

  assign accept_s = (state_r == ST_IDLE) && req_ready_r && req_valid;

  // With LAT==0 the commit edge is the acceptance edge, so the live request feeds the array
  assign acc_wen_s   = (state_r == ST_IDLE) ? req_wen   : wen_r;
  assign acc_addr_s  = (state_r == ST_IDLE) ? req_addr  : addr_r;
  assign acc_wdata_s = (state_r == ST_IDLE) ? req_wdata : wdata_r;
  assign acc_wmask_s = (state_r == ST_IDLE) ? req_wmask : wmask_r;

  assign off_s    = acc_addr_s - BASE;
  assign oor_s    = (acc_addr_s < BASE) || ((off_s >> 2) >= 32'(DEPTH_WORDS));
  assign arr_be_s = acc_wen_s ? acc_wmask_s : 4'h0;

  // Next-state, counter and commit strobe
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    latch_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          latch_s = 1'b1;
          if (LAT == 0) begin
            state_s  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = LAT_CNT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // FSM state, handshake outputs and response status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      err_r        <= 1'b0;
      rd_gate_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_RESP);
      if (commit_s) begin
        err_r     <= oor_s;
        rd_gate_r <= !acc_wen_s && !oor_s;
      end else if ((state_r == ST_RESP) && resp_ready) begin
        err_r     <= 1'b0;
        rd_gate_r <= 1'b0;
      end
    end
  end

  // Request capture at acceptance; the master may change req_* afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_r   <= 1'b0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
      wmask_r <= 4'h0;
    end else if (latch_s) begin
      wen_r   <= req_wen;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wmask_r <= req_wmask;
    end
  end

  ysyx_25020047_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (commit_s && !oor_s),
    .be    (arr_be_s),
    .idx   (off_s[AW+1:2]),
    .wdata (acc_wdata_s),
    .rdata (arr_rdata_s)
  );

  ysyx_25020047_lsu_sram_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid)
  );

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = err_r;
  assign resp_rdata = (resp_valid_r && rd_gate_r) ? arr_rdata_s : 32'h0;

endmodule

// File: tb/tb_ysyx_25020047_lsu_sram.sv
// Directed bench for ysyx_25020047_lsu_sram: a LAT=2 instance with a shadow
// memory model, plus a LAT=0 instance for back-to-back timing.
module tb_ysyx_25020047_lsu_sram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_wmask = 4'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_wen = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0;
  logic [3:0]  b_req_wmask = 4'h0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  ysyx_25020047_lsu_sram #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  ysyx_25020047_lsu_sram #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    if (m[0]) r[7:0]   = wd[7:0];
    if (m[1]) r[15:8]  = wd[15:8];
    if (m[2]) r[23:16] = wd[23:16];
    if (m[3]) r[31:24] = wd[31:24];
    return r;
  endfunction

  // One full transaction on the LAT=2 instance; lat counts negedges from acceptance to resp_valid
  task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, output logic [31:0] rdata,
                      output logic err, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = ~wen; req_addr = ~addr; req_wdata = ~wdata; req_wmask = ~mask;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 50);
    chk("resp_valid_timeout", {31'b0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          guard;

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Preload the whole array with a known pattern
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = (32'h0101_0101 * 32'(i)) ^ 32'hA5A5_5A5A;
    end
    model[8]  = 32'h1122_3344;
    model[16] = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b1, BASE + (32'(i) << 2), model[i], 4'hF, rd, er, lat);
    end

    // Write then read with LAT=2 latency
    xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    model[4] = 32'hDEAD_BEEF;
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_err", {31'b0, er}, 32'd0);
    chk("wr_rdata_zero", rd, 32'h0);
    xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_err", {31'b0, er}, 32'd0);

    // Byte-masked writes
    xact(1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, rd, er, lat);
    model[8] = merge(model[8], 32'h0000_AA00, 4'b0010);
    xact(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    chk("mask_0010", rd, 32'h1122_AA44);
    xact(1'b1, 32'h8000_0020, 32'h5566_0000, 4'b1100, rd, er, lat);
    model[8] = merge(model[8], 32'h5566_0000, 4'b1100);
    xact(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    chk("mask_1100", rd, 32'h5566_AA44);
    xact(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    chk("mask_0000_err", {31'b0, er}, 32'd0);
    xact(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
    chk("mask_0000_data", rd, 32'h5566_AA44);

    // Range boundaries
    xact(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
    chk("oor_low_err", {31'b0, er}, 32'd1);
    chk("oor_low_rdata", rd, 32'h0);
    chk("oor_low_latency", 32'(lat), 32'd3);
    xact(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, rd, er, lat);
    chk("oor_high_err", {31'b0, er}, 32'd1);
    chk("oor_high_rdata", rd, 32'h0);
    xact(1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 4'h0, rd, er, lat);
    chk("last_word_err", {31'b0, er}, 32'd0);
    chk("last_word_data", rd, model[DEPTH-1]);
    xact(1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("oor_wr_high_err", {31'b0, er}, 32'd1);
    xact(1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("oor_wr_low_err", {31'b0, er}, 32'd1);

    // Backpressure: response held for 5 cycles, stray request ignored
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 4'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!resp_valid && guard < 50);
    chk("bp_latency", 32'(guard), 32'd3);
    for (int h = 0; h < 5; h++) begin
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_err", {31'b0, resp_err}, 32'd0);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      if (h == 1) begin
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE; req_wdata = 32'h0; req_wmask = 4'hF;
      end
      if (h == 3) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_after_resp_valid", {31'b0, resp_valid}, 32'd0);

    // Reset asserted while a write is waiting
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0040;
    req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_rdata", resp_rdata, 32'h0);
    chk("midrst_err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_post_ready", {31'b0, req_ready}, 32'd1);
    xact(1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_readback", rd, 32'h0);

    // Full-array compare against the shadow model
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b0, BASE + (32'(i) << 2), 32'h0, 4'h0, rd, er, lat);
      chk("full_array", rd, model[i]);
    end

    // LAT=0 instance: held request and resp_ready give an accept every 2 cycles
    @(negedge clk);
    b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_addr = BASE;
    b_req_wdata = 32'h1234_5678; b_req_wmask = 4'hF; b_resp_ready = 1'b1;
    chk("lat0_c0_ready", {31'b0, b_req_ready}, 32'd1);
    chk("lat0_c0_valid", {31'b0, b_resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    b_req_wen = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("lat0_ready", {31'b0, b_req_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("lat0_valid", {31'b0, b_resp_valid}, (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c % 2 == 1) begin
        chk("lat0_rdata", b_resp_rdata, (c == 1) ? 32'h0 : 32'h1234_5678);
        chk("lat0_err", {31'b0, b_resp_err}, 32'd0);
      end
    end
    b_req_valid = 1'b0;
    b_resp_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
